// File: rtl/sr04_emu_if.sv
// rtl/sr04_emu_if.sv - bus signal bundle for the SR04 echo emulator
interface sr04_emu_if;
    logic       WE_I;
    logic       TGA_I;
    logic       STB_I;
    logic [7:0] ADR_I;
    logic       STALL_O;
    logic       ACK_O;
    logic [7:0] DAT_I;
    logic [7:0] DAT_O;

    modport master (
        output WE_I, TGA_I, STB_I, ADR_I, DAT_I,
        input  STALL_O, ACK_O, DAT_O
    );

    modport slave (
        input  WE_I, TGA_I, STB_I, ADR_I, DAT_I,
        output STALL_O, ACK_O, DAT_O
    );
endinterface

// File: rtl/sr04_emu.sv
// rtl/sr04_emu.sv - HC-SR04 ultrasonic sensor emulator driving seven echo channels
`ifndef U1CLK
`define U1CLK 0
`endif
`ifndef MXCLK
`define MXCLK 3
`endif

module sr04_emu (
    input  logic            CLK_I,
    input  logic            RST_I,
    sr04_emu_if.slave       bus,
    input  logic [`MXCLK:0] clocks,
    inout  wire  [7:0]      pins
);
    typedef enum logic [1:0] { IDLE, ARMED, DELAY, ECHO } state_t;

    state_t      state;
    logic [3:0]  qcnt;
    logic [7:0]  dcnt;
    logic [15:0] ucnt;
    logic [15:0] width [7];
    logic [6:0]  mask;
    logic        notify;
    logic [7:0]  count;
    logic        sendflag;
    logic        trg_meta;
    logic        trg;
    logic [6:0]  echo;

    logic        u1clk;
    logic        myaddr;
    logic        reg_wr;
    logic        reg_rd;
    logic [3:0]  radr;
    logic [6:0]  live;
    logic [15:0] wsel;
    logic [7:0]  rd_data;
    logic        unused_clocks;

    assign u1clk         = clocks[`U1CLK];
    assign unused_clocks = ^clocks;

    assign myaddr      = bus.STB_I && (bus.ADR_I[7:4] == 4'h0);
    assign radr        = bus.ADR_I[3:0];
    assign reg_wr      = myaddr && bus.TGA_I && bus.WE_I;
    assign reg_rd      = myaddr && bus.TGA_I && !bus.WE_I;
    assign bus.ACK_O   = myaddr;
    assign bus.STALL_O = 1'b0;

    // pins[0] is the host trigger and is only ever sampled here
    assign pins[7:1] = echo;

    // Channels still inside their echo window at the current microsecond count
    always_comb begin
        live = 7'd0;
        for (int k = 0; k < 7; k++) begin
            live[k] = mask[k] && (ucnt < width[k]);
        end
    end

    // Read data mux; polls report the notification flag, foreign addresses pass DAT_I through
    always_comb begin
        wsel    = 16'h0000;
        rd_data = 8'h00;
        for (int k = 0; k < 7; k++) begin
            if (radr[3:1] == k[2:0]) begin
                wsel = width[k];
            end
        end
        if (radr == 4'd14) begin
            rd_data = {notify, mask};
        end else if (radr == 4'd15) begin
            rd_data = count;
        end else if (radr[0]) begin
            rd_data = wsel[7:0];
        end else begin
            rd_data = wsel[15:8];
        end

        if (!myaddr) begin
            bus.DAT_O = bus.DAT_I;
        end else if (bus.TGA_I) begin
            bus.DAT_O = rd_data;
        end else begin
            bus.DAT_O = {7'b0, sendflag};
        end
    end

    // Host-writable configuration; changes land immediately, even mid-echo
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            for (int k = 0; k < 7; k++) begin
                width[k] <= 16'h0000;
            end
            mask   <= 7'h00;
            notify <= 1'b0;
        end else if (reg_wr) begin
            if (radr == 4'd14) begin
                {notify, mask} <= bus.DAT_I;
            end else if (radr != 4'd15) begin
                for (int k = 0; k < 7; k++) begin
                    if (radr[3:1] == k[2:0]) begin
                        if (radr[0]) begin
                            width[k][7:0] <= bus.DAT_I;
                        end else begin
                            width[k][15:8] <= bus.DAT_I;
                        end
                    end
                end
            end
        end
    end

    // Two-flop synchronizer for the asynchronous host trigger
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            trg_meta <= 1'b0;
            trg      <= 1'b0;
        end else begin
            trg_meta <= pins[0];
            trg      <= trg_meta;
        end
    end

    // Trigger qualification, 200 us ranging delay, echo generation and cycle bookkeeping
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state    <= IDLE;
            qcnt     <= 4'd0;
            dcnt     <= 8'd0;
            ucnt     <= 16'd0;
            count    <= 8'd0;
            sendflag <= 1'b0;
            echo     <= 7'd0;
        end else begin
            echo <= 7'd0;
            if (reg_rd) begin
                sendflag <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!trg) begin
                        qcnt <= 4'd0;
                    end else if (u1clk) begin
                        if (qcnt == 4'd9) begin
                            state <= ARMED;
                            qcnt  <= 4'd0;
                        end else begin
                            qcnt <= qcnt + 4'd1;
                        end
                    end
                end
                ARMED: begin
                    if (!trg) begin
                        state <= DELAY;
                        dcnt  <= 8'd0;
                    end
                end
                DELAY: begin
                    if (u1clk) begin
                        if (dcnt == 8'd199) begin
                            state <= ECHO;
                            ucnt  <= 16'd0;
                        end else begin
                            dcnt <= dcnt + 8'd1;
                        end
                    end
                end
                ECHO: begin
                    if ((live == 7'd0) || (ucnt == 16'hFFFF)) begin
                        state <= IDLE;
                        qcnt  <= 4'd0;
                        count <= count + 8'd1;
                        if (notify && !reg_rd) begin
                            sendflag <= 1'b1;
                        end
                    end else begin
                        echo <= live;
                        if (u1clk && (ucnt != 16'hFFFF)) begin
                            ucnt <= ucnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr04_emu.sv
// tb/tb_sr04_emu.sv - randomized and directed self-checking bench for sr04_emu
`ifndef U1CLK
`define U1CLK 0
`endif
`ifndef MXCLK
`define MXCLK 3
`endif

module tb_sr04_emu;
    localparam int P = 4;

    localparam int M_WAIT      = 0;
    localparam int M_HELD      = 1;
    localparam int M_COUNTDOWN = 2;
    localparam int M_ECHO      = 3;

    logic            CLK_I = 1'b0;
    logic            RST_I = 1'b1;
    logic            u1    = 1'b0;
    logic            trig  = 1'b0;
    logic [`MXCLK:0] clocks;
    wire  [7:0]      pins;
    int              div    = 0;
    int              ntests = 0;
    int              nfail  = 0;

    // reference model state
    logic [15:0] m_w [7];
    logic [6:0]  m_mask;
    logic        m_notify;
    logic [7:0]  m_count;
    logic        m_flag;
    logic [6:0]  m_out;
    logic        m_s0, m_s1;
    int          m_mode, m_hi, m_dly, m_el;

    sr04_emu_if bus();

    assign pins[0] = trig;

    always_comb begin
        clocks = '0;
        clocks[`U1CLK] = u1;
    end

    sr04_emu dut (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .bus    (bus),
        .clocks (clocks),
        .pins   (pins)
    );

    always #5 CLK_I = ~CLK_I;

    initial forever begin
        @(negedge CLK_I);
        #1;
        u1  = (div == P - 1);
        div = (div + 1) % P;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 7; k++) m_w[k] = 16'h0;
        m_mask = 7'h0; m_notify = 1'b0; m_count = 8'h0; m_flag = 1'b0; m_out = 7'h0;
        m_s0 = 1'b0; m_s1 = 1'b0;
        m_mode = M_WAIT; m_hi = 0; m_dly = 0; m_el = 0;
    endtask

    task automatic model_step();
        logic       acc, wr, rd, trg_now;
        logic [3:0] a;
        logic [6:0] live;
        int         idx;
        trg_now = m_s1;
        acc = bus.STB_I && (bus.ADR_I[7:4] == 4'h0) && bus.TGA_I;
        wr  = acc && bus.WE_I;
        rd  = acc && !bus.WE_I;
        a   = bus.ADR_I[3:0];
        idx = int'(a) / 2;
        m_out = 7'h0;
        case (m_mode)
            M_WAIT: begin
                if (!trg_now) m_hi = 0;
                else if (u1) begin
                    m_hi++;
                    if (m_hi >= 10) begin m_mode = M_HELD; m_hi = 0; end
                end
            end
            M_HELD: if (!trg_now) begin m_mode = M_COUNTDOWN; m_dly = 0; end
            M_COUNTDOWN: if (u1) begin
                m_dly++;
                if (m_dly == 200) begin m_mode = M_ECHO; m_el = 0; end
            end
            M_ECHO: begin
                live = 7'h0;
                for (int k = 0; k < 7; k++)
                    if (m_mask[k] && (m_el < int'(m_w[k]))) live[k] = 1'b1;
                if (live == 7'h0 || m_el == 65535) begin
                    m_mode = M_WAIT; m_hi = 0;
                    m_count = m_count + 8'd1;
                    if (m_notify) m_flag = 1'b1;
                end else begin
                    m_out = live;
                    if (u1) m_el++;
                end
            end
            default: ;
        endcase
        if (rd) m_flag = 1'b0;
        if (wr) begin
            if (a == 4'd14) {m_notify, m_mask} = bus.DAT_I;
            else if (a != 4'd15) begin
                if (a[0]) m_w[idx][7:0] = bus.DAT_I;
                else m_w[idx][15:8] = bus.DAT_I;
            end
        end
        m_s1 = m_s0;
        m_s0 = trig;
    endtask

    function automatic logic [7:0] exp_dat();
        int idx;
        if (!(bus.STB_I && bus.ADR_I[7:4] == 4'h0)) return bus.DAT_I;
        if (!bus.TGA_I) return m_flag ? 8'd1 : 8'd0;
        if (bus.ADR_I[3:0] == 4'd14) return {m_notify, m_mask};
        if (bus.ADR_I[3:0] == 4'd15) return m_count;
        idx = int'(bus.ADR_I[3:0]) / 2;
        return bus.ADR_I[0] ? m_w[idx][7:0] : m_w[idx][15:8];
    endfunction

    always @(posedge CLK_I) begin
        if (RST_I) model_reset();
        else model_step();
    end

    always @(negedge CLK_I) begin
        if (!RST_I) begin
            check("echo_pins", 32'(pins[7:1]), 32'(m_out));
            check("ack", 32'(bus.ACK_O), 32'(bus.STB_I && bus.ADR_I[7:4] == 4'h0));
            check("dat_o", 32'(bus.DAT_O), 32'(exp_dat()));
            check("stall", 32'(bus.STALL_O), 32'd0);
        end
    end

    task automatic bus_idle();
        bus.STB_I = 1'b0; bus.TGA_I = 1'b0; bus.WE_I = 1'b0;
        bus.ADR_I = 8'h00; bus.DAT_I = 8'h00;
    endtask

    task automatic bus_cycle(input logic stb, input logic tga, input logic we,
                             input logic [7:0] adr, input logic [7:0] dat, output logic [7:0] q);
        @(negedge CLK_I);
        #1;
        bus.STB_I = stb; bus.TGA_I = tga; bus.WE_I = we; bus.ADR_I = adr; bus.DAT_I = dat;
        #2 q = bus.DAT_O;
        @(negedge CLK_I);
        #1;
        bus_idle();
    endtask

    task automatic reg_write(input logic [7:0] adr, input logic [7:0] dat);
        logic [7:0] q;
        bus_cycle(1'b1, 1'b1, 1'b1, adr, dat, q);
    endtask

    task automatic reg_read(input logic [7:0] adr, output logic [7:0] q);
        bus_cycle(1'b1, 1'b1, 1'b0, adr, 8'h00, q);
    endtask

    task automatic poll(output logic [7:0] q);
        bus_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, q);
    endtask

    task automatic drive_trig(input int n);
        @(negedge CLK_I);
        #1 trig = 1'b1;
        repeat (n) @(negedge CLK_I);
        #1 trig = 1'b0;
    endtask

    task automatic set_width(input int ch, input int w);
        reg_write(8'(2 * ch), 8'(w >> 8));
        reg_write(8'(2 * ch + 1), 8'(w & 255));
    endtask

    task automatic rand_op();
        logic [7:0] q, a, d;
        a = 8'($urandom_range(0, 15));
        d = 8'($urandom_range(0, 255));
        case ($urandom_range(0, 5))
            0: begin
                if (a < 8'd14 && !a[0]) d = 8'h00;
                reg_write(a, d);
            end
            1: reg_read(a, q);
            2: poll(q);
            3: bus_cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         8'($urandom_range(16, 255)), d, q);
            4: bus_cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), a, d, q);
            default: @(negedge CLK_I);
        endcase
    endtask

    initial begin : main
        logic [7:0] d;
        logic [6:0] prev;
        int n, cyc;
        int fall [7];

        bus_idle();
        repeat (3) @(negedge CLK_I);
        #1 RST_I = 1'b0;

        // reset state
        reg_read(8'd15, d); check("rst_count", 32'(d), 32'h00);
        reg_read(8'd14, d); check("rst_mask", 32'(d), 32'h00);
        reg_read(8'd3, d);  check("rst_width1_lo", 32'(d), 32'h00);
        poll(d);            check("rst_poll", 32'(d), 32'h00);

        // 8 us trigger never qualifies
        drive_trig(8 * P);
        repeat (1000) @(negedge CLK_I);
        check("short_trig_pins", 32'(pins[7:1]), 32'h0);
        reg_read(8'd15, d); check("short_trig_count", 32'(d), 32'h00);

        // single 580 us channel
        set_width(0, 580);
        reg_write(8'd14, 8'h01);
        reg_read(8'd0, d); check("w0_hi_readback", 32'(d), 32'h02);
        reg_read(8'd1, d); check("w0_lo_readback", 32'(d), 32'h44);
        drive_trig(12 * P);
        n = 0;
        while (!pins[1] && n < 2000) begin @(negedge CLK_I); n++; end
        check("t580_delay_in_window", 32'(n >= 796 && n <= 808), 32'd1);
        n = 0;
        while (pins[1] && n < 5000) begin @(negedge CLK_I); n++; end
        check("t580_width_in_window", 32'(n >= 580 * P - 4 && n <= 580 * P + 4), 32'd1);
        repeat (10) @(negedge CLK_I);
        reg_read(8'd15, d); check("t580_count", 32'(d), 32'h01);

        // seven staggered channels; second trigger during echo is ignored
        for (int k = 0; k < 7; k++) set_width(k, 100 * (k + 1));
        reg_write(8'd14, 8'h7F);
        drive_trig(12 * P);
        n = 0;
        while (pins[7:1] == 7'h0 && n < 2000) begin @(negedge CLK_I); n++; end
        check("stagger_started", 32'(n < 2000), 32'd1);
        drive_trig(15 * P);
        for (int k = 0; k < 7; k++) fall[k] = -1;
        prev = pins[7:1];
        check("stagger_all_high", 32'(prev), 32'h7F);
        cyc = 0;
        while (cyc < 4000 && pins[7:1] != 7'h0) begin
            @(negedge CLK_I);
            cyc++;
            for (int k = 0; k < 7; k++)
                if (prev[k] && !pins[k + 1]) fall[k] = cyc;
            prev = pins[7:1];
        end
        for (int k = 0; k < 6; k++) begin
            n = fall[k + 1] - fall[k];
            check("stagger_gap", 32'(n >= 100 * P - 1 && n <= 100 * P + 1), 32'd1);
        end
        repeat (10) @(negedge CLK_I);
        reg_read(8'd15, d); check("stagger_count", 32'(d), 32'h02);

        // notification flag
        set_width(0, 20);
        reg_write(8'd14, 8'h81);
        drive_trig(12 * P);
        poll(d); check("notify_poll_before", 32'(d), 32'h00);
        repeat (1100) @(negedge CLK_I);
        poll(d); check("notify_poll_set", 32'(d), 32'h01);
        reg_read(8'd15, d); check("notify_count", 32'(d), 32'h03);
        poll(d); check("notify_poll_cleared", 32'(d), 32'h00);

        // empty mask: one-clock echo, still counted
        reg_write(8'd14, 8'h00);
        drive_trig(12 * P);
        repeat (1000) @(negedge CLK_I);
        reg_read(8'd15, d); check("mask0_count", 32'(d), 32'h04);

        // randomized cycles with live bus traffic
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < 7; k++) set_width(k, int'($urandom_range(0, 40)));
            reg_write(8'd14, 8'($urandom_range(0, 255)));
            drive_trig(int'($urandom_range(5 * P, 17 * P)));
            for (int j = 0; j < 700; j++) rand_op();
            n = 0;
            while (m_mode != M_WAIT && n < 3000) begin @(negedge CLK_I); n++; end
            check("rand_settle", 32'(n < 3000), 32'd1);
            repeat (20) @(negedge CLK_I);
        end

        // reset in the middle of an echo
        set_width(0, 300);
        reg_write(8'd14, 8'h81);
        drive_trig(12 * P);
        n = 0;
        while (!pins[1] && n < 2000) begin @(negedge CLK_I); n++; end
        check("rst_echo_started", 32'(n < 2000), 32'd1);
        repeat (50) @(negedge CLK_I);
        #1 RST_I = 1'b1;
        #1 check("rst_echo_pins_low", 32'(pins[7:1]), 32'h0);
        repeat (3) @(negedge CLK_I);
        #1 RST_I = 1'b0;
        for (int a = 0; a < 16; a++) begin
            reg_read(8'(a), d);
            check("post_rst_reg", 32'(d), 32'h00);
        end
        poll(d); check("post_rst_poll", 32'(d), 32'h00);

        repeat (5) @(negedge CLK_I);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/sr04_emu.md
SR04_EMU -- requirements
Module: sr04emu

Interface
REQ-001 Parameters: none; clock pulse indices come from the system-wide clock defines (U1CLK).
REQ-002 CLK_I  input  1  system clock; all state changes on rising edge.
REQ-003 RST_I  input  1  reset, asynchronous, active-high.
REQ-004 WE_I  input  1  bus direction, read=0, write=1.
REQ-005 TGA_I  input  1  1=register access, 0=poll.
REQ-006 STB_I  input  1  1=this peripheral addressed.
REQ-007 ADR_I  input  8  register address.
REQ-008 STALL_O  output  1  tied 0.
REQ-009 ACK_O  output  1  equals myaddr (STB_I and ADR_I[7:4]==0).
REQ-010 DAT_I  input  8  bus write data / pass-through data.
REQ-011 DAT_O  output  8  read data; equals DAT_I when not myaddr.
REQ-012 clocks  input  MXCLK+1  utility pulse array; only u1clk (1 us, one CLK_I wide) used.
REQ-013 pins  inout  8  pins[0]=trigger input from host, never driven; pins[7:1]=echo outputs for emulated sensors 1..7.

Function
REQ-014 Registers: addr 2k/2k+1 (k=0..6) = width[k] high/low byte, echo width in us, R/W; addr 14 = bit7 notify, bits6:0 mask, R/W; addr 15 = 8-bit completed-cycle count, read-only, writes ignored.
REQ-015 Register writes take effect on the clock after TGA_I&myaddr&WE_I; mask and width writes apply immediately, including mid-ECHO.
REQ-016 Trigger synchronized by two flops; all trigger decisions use the synchronized value (trg).
REQ-017 States: IDLE, ARMED, DELAY, ECHO.
REQ-018 IDLE: on each u1clk with trg=1, qcnt++; trg=0 on any clock clears qcnt; qcnt reaching 10 -> ARMED, qcnt cleared.
REQ-019 ARMED: stay while trg=1 (no timeout); trg=0 -> DELAY, dcnt=0.
REQ-020 DELAY: dcnt++ on each u1clk; u1clk with dcnt==199 -> ECHO, ucnt=0 (200 us delay).
REQ-021 ECHO: ucnt (16-bit) ++ on each u1clk, saturating at 16'hFFFF; echo[k] registered = mask[k] & (ucnt < width[k]).
REQ-022 ECHO exit: on the clock where no enabled channel satisfies ucnt < width[k], or ucnt==16'hFFFF -> IDLE, qcnt=0, cycle count++ (wraps 255->0), sendflag set if notify=1.
REQ-023 width[k]==0 or mask[k]==0: channel stays low for the whole cycle; mask==0 gives ECHO of one clock then IDLE.
REQ-024 Trigger activity in DELAY/ECHO ignored; a trigger still high on return to IDLE must qualify anew (10 u1clk).
REQ-025 Echo pulse high time = width[k] u1clk periods, within +/-1 CLK_I.
REQ-026 Outputs echo pins low in all states except ECHO.
REQ-027 Poll (~TGA_I, myaddr) with sendflag=1: DAT_O=8'd1; sendflag=0: DAT_O=DAT_I passthrough of 8'h00 rule not applied, DAT_O=8'h00.
REQ-028 Any register read (TGA_I&myaddr&~WE_I) clears sendflag; set on same clock as clear wins set.
REQ-029 Register reads: width high byte at even addr, low byte at odd; addr 14 returns {notify,mask}; addr 15 returns count.

Reset
REQ-030 RST_I asserted: state=IDLE, qcnt/dcnt/ucnt=0, widths=0, mask=0, notify=0, count=0, sendflag=0, sync flops=0, pins[7:1]=0, immediately and asynchronously.
REQ-031 Reset mid-ECHO drops all echo pins low without waiting for a clock; no count increment.

Verification
REQ-032 width[0]=580, mask=7'h01; trigger high 12 us then low -> pins[1] rises 200 us (+/-1 us) after trigger fall, high 580 us, count=1.
REQ-033 Trigger high 8 us -> no state change, pins[7:1]=0, count unchanged.
REQ-034 width[0..6]=100,200..700, mask=7'h7F -> seven staggered pulses, each ending 100 us apart; single count increment after 700 us.
REQ-035 notify=1; complete cycle -> poll returns 8'd1; read addr 15 -> 8'h01 and next poll returns 8'h00.
REQ-036 Second trigger during ECHO ignored; RST_I asserted mid-ECHO -> pins low at once, all registers read 0.
